// File: rtl/vec_dsp_if.sv
// Bundles the vector issue, DSP handshake and VRF write signals of the vector sequencer.
// The master side is the sequencer; the slave side is ID, the DSP unit and the VRF.
interface vec_dsp_if #(
   parameter int ELEM_W = 32,
   parameter int IDX_W  = 3
);
   logic              issue_valid;
   logic [2:0]        issue_funct3;
   logic [4:0]        issue_vd;
   logic [4:0]        issue_vs1;
   logic [4:0]        issue_vs2;
   logic [IDX_W:0]    issue_vl;
   logic              stall;
   logic              busy;
   logic              dsp_start;
   logic [2:0]        dsp_op;
   logic [4:0]        vs1_addr;
   logic [4:0]        vs2_addr;
   logic [IDX_W-1:0]  elem_idx;
   logic              dsp_done;
   logic [ELEM_W-1:0] dsp_result;
   logic              vrf_we;
   logic [4:0]        vrf_waddr;
   logic [IDX_W-1:0]  vrf_widx;
   logic [ELEM_W-1:0] vrf_wdata;
   logic              done;
   logic              err;
   logic [2:0]        dbg_state;

   modport master (
      input  issue_valid, issue_funct3, issue_vd, issue_vs1, issue_vs2, issue_vl,
      input  dsp_done, dsp_result,
      output stall, busy, dsp_start, dsp_op, vs1_addr, vs2_addr, elem_idx,
      output vrf_we, vrf_waddr, vrf_widx, vrf_wdata, done, err, dbg_state
   );

   modport slave (
      output issue_valid, issue_funct3, issue_vd, issue_vs1, issue_vs2, issue_vl,
      output dsp_done, dsp_result,
      input  stall, busy, dsp_start, dsp_op, vs1_addr, vs2_addr, elem_idx,
      input  vrf_we, vrf_waddr, vrf_widx, vrf_wdata, done, err, dbg_state
   );
endinterface

// File: rtl/vec_dsp_seq.sv
// Walks a vector instruction through the shared scalar DSP one element at a time,
// stalling IF/ID and writing each result into the VRF; flags illegal or hung operations.
// Handshake: dsp_start is high for the single START cycle; dsp_done is only honoured in WAIT.
module vec_dsp_seq #(
   parameter int ELEM_W  = 32,
   parameter int VLEN    = 8,
   parameter int IDX_W   = 3,
   parameter int TIMEOUT = 16
) (
   input logic      clk,
   input logic      rst_n,
   vec_dsp_if.master bus
);
   localparam int             CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W:0]   VL_MAX  = (IDX_W + 1)'(VLEN);

   typedef enum logic [2:0] {IDLE, START, WAIT, WB, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q;
   logic [4:0]        vs1_q, vs2_q, vd_q;
   logic [IDX_W:0]    vl_q;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ELEM_W-1:0] wdata_q;
   logic              err_q, err_d;
   logic              issue_illegal, latch_issue, capture, in_seq;

   assign issue_illegal = (bus.issue_funct3 == 3'b111) || (bus.issue_vl > VL_MAX);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      err_d       = 1'b0;
      latch_issue = 1'b0;
      capture     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.issue_valid) begin
               if (issue_illegal) begin
                  err_d = 1'b1;
               end else if (bus.issue_vl == '0) begin
                  state_d = DONE;
               end else begin
                  latch_issue = 1'b1;
                  idx_d       = '0;
                  state_d     = START;
               end
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.dsp_done) begin
               capture = 1'b1;
               state_d = WB;
            end else if (cnt_q == CNT_MAX) begin
               // DSP hung: abandon the whole sequence without writing this element
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WB: begin
            if ({1'b0, idx_q} == vl_q - 1'b1) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = START;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         vd_q    <= '0;
         vl_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (latch_issue) begin
            op_q  <= bus.issue_funct3;
            vs1_q <= bus.issue_vs1;
            vs2_q <= bus.issue_vs2;
            vd_q  <= bus.issue_vd;
            vl_q  <= bus.issue_vl;
         end
         if (capture) wdata_q <= bus.dsp_result;
      end
   end

   assign in_seq        = (state_q == START) || (state_q == WAIT) || (state_q == WB);
   // Stall already in the accepting cycle so ID keeps the instruction until DONE
   assign bus.stall     = in_seq || ((state_q == IDLE) && bus.issue_valid && !issue_illegal
                                     && (bus.issue_vl != '0));
   assign bus.busy      = in_seq;
   assign bus.dsp_start = (state_q == START);
   assign bus.dsp_op    = op_q;
   assign bus.vs1_addr  = vs1_q;
   assign bus.vs2_addr  = vs2_q;
   assign bus.elem_idx  = idx_q;
   assign bus.vrf_we    = (state_q == WB);
   assign bus.vrf_waddr = vd_q;
   assign bus.vrf_widx  = idx_q;
   assign bus.vrf_wdata = wdata_q;
   assign bus.done      = (state_q == DONE);
   assign bus.err       = err_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_vec_dsp_seq.sv
// Directed plus randomized bench for vec_dsp_seq with a responding DSP model and
// a timing model derived from the per-element START / WAIT(delay) / WB sequence.
module tb_vec_dsp_seq;
   logic clk;
   logic rst_n;

   vec_dsp_if #(.ELEM_W(32), .IDX_W(3)) bus ();

   vec_dsp_seq #(.ELEM_W(32), .VLEN(8), .IDX_W(3), .TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int issue_cyc = 0;
   int stall_n = 0;

   logic [39:0] wr_q[$];
   logic [12:0] opsig_q[$];
   int          start_q[$];
   int          done_q[$];
   int          err_q[$];

   int          delay_tab[8];
   logic [31:0] res_tab[8];
   bit          spur_tab[8];
   bit          ack_en;
   int          dsp_cnt = 0;
   logic [31:0] pend_res;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {2'b00, bus.stall, bus.busy, bus.dsp_start, bus.dsp_op, bus.vs1_addr, bus.vs2_addr,
              bus.elem_idx, bus.vrf_we, bus.vrf_waddr, bus.vrf_widx, bus.vrf_wdata, bus.done, bus.err};
   endfunction

   // One cycle: observe outputs at the negedge, then let the DSP model respond.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (bus.vrf_we) wr_q.push_back({bus.vrf_waddr, bus.vrf_widx, bus.vrf_wdata});
      if (bus.dsp_start) begin
         start_q.push_back(cyc);
         opsig_q.push_back({bus.dsp_op, bus.vs1_addr, bus.vs2_addr});
      end
      if (bus.done) done_q.push_back(cyc);
      if (bus.err) err_q.push_back(cyc);
      if (bus.stall) stall_n++;
      bus.dsp_done = 1'b0;
      if (dsp_cnt > 0) begin
         dsp_cnt--;
         if (dsp_cnt == 0) begin
            bus.dsp_done   = 1'b1;
            bus.dsp_result = pend_res;
         end
      end
      if (bus.dsp_start && ack_en) begin
         dsp_cnt  = delay_tab[bus.elem_idx];
         pend_res = res_tab[bus.elem_idx];
         if (spur_tab[bus.elem_idx]) begin
            bus.dsp_done   = 1'b1;
            bus.dsp_result = 32'hdead_beef;
         end
      end
   endtask

   task automatic set_tabs(input int delay, input bit rand_delay);
      for (int i = 0; i < 8; i++) begin
         delay_tab[i] = rand_delay ? int'($urandom_range(1, 4)) : delay;
         res_tab[i]   = $urandom;
         spur_tab[i]  = 1'b0;
      end
   endtask

   task automatic drive_issue(input logic [2:0] f3, input logic [4:0] vd, input logic [4:0] vs1,
                              input logic [4:0] vs2, input int vl);
      wr_q.delete(); opsig_q.delete(); start_q.delete(); done_q.delete(); err_q.delete();
      stall_n = 0;
      bus.issue_funct3 = f3;
      bus.issue_vd     = vd;
      bus.issue_vs1    = vs1;
      bus.issue_vs2    = vs2;
      bus.issue_vl     = 4'(vl);
      bus.issue_valid  = 1'b1;
      #1;
      issue_cyc = cyc;
      chk("stall_at_issue", bus.stall, (f3 != 3'b111) && (vl <= 8) && (vl != 0));
      step();
      bus.issue_valid = 1'b0;
   endtask

   task automatic run_issue(input logic [2:0] f3, input logic [4:0] vd, input logic [4:0] vs1,
                            input logic [4:0] vs2, input int vl);
      drive_issue(f3, vd, vs1, vs2, vl);
      for (int n = 0; n < 300 && done_q.size() == 0 && err_q.size() == 0; n++) step();
      repeat (3) step();
   endtask

   task automatic expect_vec(input string tag, input logic [2:0] f3, input logic [4:0] vd,
                             input logic [4:0] vs1, input logic [4:0] vs2, input int vl);
      int t;
      t = issue_cyc + 1;
      chk({tag, "_nstart"}, start_q.size(), vl);
      chk({tag, "_nwrite"}, wr_q.size(), vl);
      for (int i = 0; i < vl; i++) begin
         if (i < start_q.size()) begin
            chk({tag, "_start_cyc"}, start_q[i], t);
            chk({tag, "_op_addr"}, opsig_q[i], {f3, vs1, vs2});
         end
         if (i < wr_q.size()) chk({tag, "_write"}, wr_q[i], {vd, 3'(i), res_tab[i]});
         t += 2 + delay_tab[i];
      end
      chk({tag, "_ndone"}, done_q.size(), 1);
      if (done_q.size() > 0) chk({tag, "_done_cyc"}, done_q[0], t);
      chk({tag, "_nerr"}, err_q.size(), 0);
      chk({tag, "_stall_cycles"}, stall_n, t - issue_cyc - 1);
   endtask

   task automatic expect_abort(input string tag, input int err_at, input int nstart, input int nstall);
      chk({tag, "_nerr"}, err_q.size(), 1);
      if (err_q.size() > 0) chk({tag, "_err_cyc"}, err_q[0], err_at);
      chk({tag, "_nstart"}, start_q.size(), nstart);
      chk({tag, "_nwrite"}, wr_q.size(), 0);
      chk({tag, "_ndone"}, done_q.size(), 0);
      chk({tag, "_stall_cycles"}, stall_n, nstall);
      chk({tag, "_idle_after"}, {bus.busy, bus.stall}, 2'b00);
   endtask

   initial begin
      logic [2:0] f3;
      logic [4:0] vd, vs1, vs2;
      int         vl;

      rst_n = 1'b0;
      ack_en = 1'b1;
      bus.issue_valid = 1'b0; bus.issue_funct3 = '0; bus.issue_vd = '0;
      bus.issue_vs1 = '0; bus.issue_vs2 = '0; bus.issue_vl = '0;
      bus.dsp_done = 1'b0; bus.dsp_result = '0;
      set_tabs(1, 1'b0);
      repeat (2) step();
      chk("reset_outputs", outs(), 64'd0);
      rst_n = 1'b1;
      step();
      chk("idle_outputs", outs(), 64'd0);

      // Basic 4-element vector, single-cycle DSP ack
      set_tabs(1, 1'b0);
      res_tab[0] = 32'h11; res_tab[1] = 32'h22; res_tab[2] = 32'h33; res_tab[3] = 32'h44;
      run_issue(3'b000, 5'd5, 5'd1, 5'd2, 4);
      expect_vec("vl4", 3'b000, 5'd5, 5'd1, 5'd2, 4);
      chk("vl4_latency", done_q.size() > 0 ? done_q[0] - issue_cyc : -1, 13);

      // Empty vector completes without touching the DSP
      run_issue(3'b010, 5'd7, 5'd3, 5'd4, 0);
      expect_vec("vl0", 3'b010, 5'd7, 5'd3, 5'd4, 0);

      // Illegal issues
      run_issue(3'b001, 5'd9, 5'd1, 5'd1, 9);
      expect_abort("vl9", issue_cyc + 1, 0, 0);
      run_issue(3'b111, 5'd9, 5'd1, 5'd1, 3);
      expect_abort("f3_111", issue_cyc + 1, 0, 0);
      set_tabs(1, 1'b0);
      run_issue(3'b011, 5'd30, 5'd8, 5'd9, 8);
      expect_vec("after_illegal", 3'b011, 5'd30, 5'd8, 5'd9, 8);

      // Hung DSP: one START then 16 WAIT cycles, err the cycle after
      ack_en = 1'b0;
      run_issue(3'b100, 5'd12, 5'd2, 5'd3, 2);
      expect_abort("timeout", issue_cyc + 18, 1, 17);
      ack_en = 1'b1;

      // Slow ack on element 1 plus a spurious ack in its START cycle
      set_tabs(1, 1'b0);
      delay_tab[1] = 5;
      spur_tab[1]  = 1'b1;
      run_issue(3'b101, 5'd17, 5'd6, 5'd7, 4);
      expect_vec("slow_spur", 3'b101, 5'd17, 5'd6, 5'd7, 4);
      chk("slow_spur_latency", done_q.size() > 0 ? done_q[0] - issue_cyc : -1, 17);

      // Reset during WAIT of element 2
      set_tabs(1, 1'b0);
      drive_issue(3'b110, 5'd21, 5'd10, 5'd11, 4);
      for (int n = 0; n < 50 && cyc < issue_cyc + 8; n++) step();
      chk("pre_reset_starts", start_q.size(), 3);
      rst_n = 1'b0;
      step();
      chk("midseq_reset_outputs", outs(), 64'd0);
      rst_n = 1'b1;
      repeat (20) step();
      chk("midseq_nwrite", wr_q.size(), 2);
      chk("midseq_nstart", start_q.size(), 3);
      chk("midseq_ndone", done_q.size(), 0);
      chk("midseq_nerr", err_q.size(), 0);
      set_tabs(1, 1'b0);
      run_issue(3'b001, 5'd4, 5'd5, 5'd6, 3);
      expect_vec("post_reset", 3'b001, 5'd4, 5'd5, 5'd6, 3);

      // Randomized legal vectors with random DSP latency
      for (int k = 0; k < 6; k++) begin
         f3  = 3'($urandom_range(0, 6));
         vd  = 5'($urandom);
         vs1 = 5'($urandom);
         vs2 = 5'($urandom);
         vl  = int'($urandom_range(1, 8));
         set_tabs(1, 1'b1);
         spur_tab[$urandom_range(0, 7)] = 1'b1;
         run_issue(f3, vd, vs1, vs2, vl);
         expect_vec("random", f3, vd, vs1, vs2, vl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
